// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_seq channel multiplexer: mode encodings,
// default geometry, and width / parity helper functions.
package muxn_pkg;

    // Mode encodings for the 'mode' input
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Default geometry
    localparam int DEF_W = 8;
    localparam int DEF_N = 4;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Channel index width, never narrower than one bit
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Even-parity bit of a word (zero-extended to 64 bits by the caller)
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of 'valid' at or above
// 'ptr', wrapping from N-1 back to 0. 'ptr' is expected to be below N.
module rr_pick
    import muxn_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int SW = sel_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    // Walk the channels in priority order starting at ptr; first hit wins
    always_comb begin
        found = 1'b0;
        idx   = {SW{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (!found && valid[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = SW'((int'(ptr) + k) % N);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/muxn_seq.sv
// muxn_seq: N-channel to one registered output multiplexer with manual
// select or round-robin scan. Optional feature macro MUXN_SEQ_PARITY_EN adds
// a registered even-parity output out_parity alongside out_data.
module muxn_seq
    import muxn_pkg::*;
#(
    parameter  int W  = DEF_W,
    parameter  int N  = DEF_N,
    localparam int SW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_chan,
    output logic            out_valid,
    input  logic            out_ready
`ifdef MUXN_SEQ_PARITY_EN
    ,
    output logic            out_parity
`endif
);

    // Index space covered by sel; channels at or above N read as invalid
    localparam int NP = 1 << SW;

    logic [W-1:0]    out_data_r;
    logic [SW-1:0]   out_chan_r;
    logic            out_valid_r;
    logic [SW-1:0]   ptr_r;

    logic [NP-1:0]   valid_ext_s;
    logic [NP*W-1:0] data_ext_s;
    logic            pick_found_s;
    logic [SW-1:0]   pick_idx_s;
    logic            grant_s;
    logic [SW-1:0]   gidx_s;
    logic            free_s;
    logic            accept_s;
    logic [SW-1:0]   ptr_nxt_s;
    logic [W-1:0]    sel_data_s;
    logic [N-1:0]    in_ready_s;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .valid (in_valid),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Zero-extend valid/data so an out-of-range sel simply sees no request
    always_comb begin
        valid_ext_s          = {NP{1'b0}};
        data_ext_s           = {(NP*W){1'b0}};
        valid_ext_s[N-1:0]   = in_valid;
        data_ext_s[N*W-1:0]  = in_data;
    end

    // Choose the candidate channel for this cycle according to mode
    always_comb begin
        grant_s = 1'b0;
        gidx_s  = {SW{1'b0}};
        case (mode)
            MODE_MANUAL: begin
                grant_s = valid_ext_s[sel];
                gidx_s  = sel;
            end
            MODE_SCAN: begin
                grant_s = pick_found_s;
                gidx_s  = pick_idx_s;
            end
            default: begin
                grant_s = 1'b0;
                gidx_s  = {SW{1'b0}};
            end
        endcase
    end

    // Handshake: register free when empty or draining; accept on a grant
    always_comb begin
        free_s     = ~out_valid_r | out_ready;
        accept_s   = free_s & grant_s & rst_n;
        sel_data_s = data_ext_s[int'(gidx_s)*W +: W];
        if (gidx_s == SW'(N - 1)) begin
            ptr_nxt_s = {SW{1'b0}};
        end else begin
            ptr_nxt_s = gidx_s + {{(SW-1){1'b0}}, 1'b1};
        end
        if (accept_s) begin
            in_ready_s = {{(N-1){1'b0}}, 1'b1} << gidx_s;
        end else begin
            in_ready_s = {N{1'b0}};
        end
    end

    // Output register and scan pointer; ptr only advances on scan transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {W{1'b0}};
            out_chan_r  <= {SW{1'b0}};
            out_valid_r <= 1'b0;
            ptr_r       <= {SW{1'b0}};
        end else if (accept_s) begin
            out_data_r  <= sel_data_s;
            out_chan_r  <= gidx_s;
            out_valid_r <= 1'b1;
            if (mode == MODE_SCAN) begin
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (free_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef MUXN_SEQ_PARITY_EN
    logic out_parity_r;

    // Parity bit loaded together with out_data and held under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity_r <= 1'b0;
        end else if (accept_s) begin
            out_parity_r <= even_parity(64'(sel_data_s));
        end else begin
            out_parity_r <= out_parity_r;
        end
    end

    assign out_parity = out_parity_r;
`else
    // No parity output in this build
`endif

    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_s;

endmodule

// File: tb/tb_muxn_seq.sv
// Directed bench for muxn_seq (W=8, N=4): a vector table for single-cycle
// behaviour plus hand-written reset and parity sequences.
module tb_muxn_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;
`ifdef MUXN_SEQ_PARITY_EN
    logic        out_parity;
`endif

    int n_checks;
    int n_fail;

    typedef struct {
        logic       rst_before;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [7:0] exp_d;
        logic [1:0] exp_c;
    } vec_t;

    vec_t vecs[25];

    muxn_seq #(.W(8), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUXN_SEQ_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse reset for one edge; release lands 1 time unit after an edge
    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n     = 1'b0;
        in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        in_valid  = 4'b1111;
        sel       = 2'd0;
        mode      = 1'b0;
        out_ready = 1'b1;

        // Manual: sel 0..3 then a manual pick of an invalid channel
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
        vecs[3]  = '{1'b0, 1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
        vecs[4]  = '{1'b0, 1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        // Scan, all valid, 8 cycles from ptr 0 (after a reset)
        vecs[5]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[11] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
        // Scan with valid 1010 from ptr 0: grants 1, 3, 1
        vecs[13] = '{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[14] = '{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
        vecs[15] = '{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        // Stall 3 cycles (ptr = 2), then resume at 2, 3
        vecs[16] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        vecs[17] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        vecs[18] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        vecs[19] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
        vecs[20] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
        // Mode change (no accept in manual), ptr 0 retained into scan
        vecs[21] = '{1'b0, 1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[22] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};
        // No candidate: output drains; then wrap from ptr 1 to channel 0
        vecs[23] = '{1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[24] = '{1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};

        // Reset state, with requests present
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_chan",  64'(out_chan),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            if (vecs[i].rst_before) begin
                pulse_reset();
            end
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_d));
                chk($sformatf("v%0d_out_chan", i), 64'(out_chan), 64'(vecs[i].exp_c));
            end
        end

        // Mid-stream reset: advance ptr, then reset asynchronously between edges
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data",  64'(out_data),  64'd0);
        chk("mid_rst_out_chan",  64'(out_chan),  64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 64'(out_valid), 64'd1);
        chk("post_rst_out_chan",  64'(out_chan),  64'd0);

`ifdef MUXN_SEQ_PARITY_EN
        // Parity of loaded words: A7 has five ones, A5 has four
        in_data  = {8'h33, 8'h22, 8'hA5, 8'hA7};
        mode     = 1'b0;
        sel      = 2'd0;
        @(posedge clk);
        #1;
        chk("par_a7_data", 64'(out_data),   64'hA7);
        chk("par_a7",      64'(out_parity), 64'd1);
        sel = 2'd1;
        @(posedge clk);
        #1;
        chk("par_a5_data", 64'(out_data),   64'hA5);
        chk("par_a5",      64'(out_parity), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muxn_seq.md
MUXN_SEQ -- requirements
Module: muxn_seq

Interface
REQ-001 Parameter W, default 8: data width per channel, 1 to 64.
REQ-002 Parameter N, default 4: channel count, 2 to 16; SW = max(1, clog2(N)).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_data  in  N*W  channel i occupies bits [i*W +: W].
REQ-007 in_valid  in  N  per-channel data-valid.
REQ-008 in_ready  out  N  per-channel accept; at most one bit high per cycle.
REQ-009 sel  in  SW  channel index, used only in manual mode.
REQ-010 mode  in  1  0 = manual select, 1 = round-robin scan.
REQ-011 out_data  out  W  registered selected data.
REQ-012 out_chan  out  SW  index of the channel held in out_data.
REQ-013 out_valid  out  1  output register holds data.
REQ-014 out_ready  in  1  downstream accept.

Function
REQ-015 The output register SHALL be free when out_valid=0 or out_ready=1 in the same cycle.
REQ-016 Manual mode: when the register is free and in_valid[sel]=1, in_ready[sel] SHALL be 1, and the next edge SHALL load in_data[sel], sel and out_valid=1.
REQ-017 Manual mode with sel >= N SHALL accept nothing and drive in_ready to 0.
REQ-018 Scan mode: the grant SHALL go to the first channel with in_valid=1, searching upward from ptr with wrap N-1 -> 0; invalid channels are skipped in the same cycle.
REQ-019 ptr SHALL update to (granted index + 1) mod N only on an accepted transfer; otherwise ptr holds.
REQ-020 Latency: in_ready/in_valid handshake at edge k SHALL give out_valid=1 with that data after edge k; throughput is one transfer per cycle with out_ready held at 1.
REQ-021 With out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold, and all in_ready bits SHALL be 0.
REQ-022 If the register is free and no candidate is valid, out_valid SHALL go to 0 at the next edge.
REQ-023 A mode change SHALL take effect in the same cycle; ptr SHALL be retained across mode changes.
REQ-024 in_ready SHALL be combinational from in_valid, sel, mode, ptr, out_valid and out_ready; there SHALL be no path from in_data to in_ready.

Reset
REQ-025 While rst_n=0: out_valid=0, out_data=0, out_chan=0, ptr=0 and in_ready=0, asynchronously.
REQ-026 Reset mid-transfer SHALL discard the held word; there is no replay.
REQ-027 Release SHALL be synchronised by the integrator; the first accept SHALL be possible at the first edge after release.

Configuration
REQ-028 Macro MUXN_SEQ_PARITY_EN SHALL add output out_parity (1 bit) as the even-parity XOR of the loaded word, registered with out_data, reset 0, and held under stall.
REQ-029 Without MUXN_SEQ_PARITY_EN the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package muxn_pkg SHALL hold:
- mode constants MODE_MANUAL = 0 and MODE_SCAN = 1;
- the clog2 function;
- default parameter values.
REQ-031 Sub-module rr_pick SHALL contain the combinational search: inputs valid[N] and ptr; outputs found and idx.
REQ-032 muxn_seq SHALL contain only the handshake, ptr and output registers.

Verification
REQ-033 Manual mode, N=4, W=8, in_data = {8'h33, 8'h22, 8'h11, 8'h00}, all valid, out_ready=1, sel 0 -> 3 -> out_data 00, 11, 22, 33 on consecutive cycles; out_chan matches sel.
REQ-034 Scan mode, all valid, out_ready=1 for 8 cycles -> out_chan sequence 0, 1, 2, 3, 0, 1, 2, 3.
REQ-035 Scan mode, in_valid = 4'b1010, ptr=0 -> grants 1, 3, 1; in_ready never 1 on channels 0 or 2.
REQ-036 Stall: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_chan stable, in_ready = 0; on release, the next grant follows ptr without skip or repeat.
REQ-037 rst_n pulsed low mid-stream -> outputs 0 immediately; after release, a scan grant starts at channel 0.
REQ-038 With MUXN_SEQ_PARITY_EN, loading 8'hA7 -> out_parity=1, and loading 8'hA5 -> out_parity=0.
